// File: rtl/fto_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// fto_sweep_ctrl
//
// Walks a shared 4-input combinational function unit through all 16 input
// combinations. After each input change it waits SETTLE cycles, samples the
// unit's output, and builds a 16-bit truth table, a minterm count and an
// optional comparison against a reference table.
//
// Parameters:
//   SETTLE   cycles abcd is held stable before f_in is sampled (1..15)
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   sweep request, accepted only in IDLE
//   expected  in   [15:0] reference table, sampled in the last SAMPLE cycle
//   abcd      out  [3:0]  function unit inputs (abcd[3]=A ... abcd[0]=D)
//   f_in      in   function unit output
//   busy      out  high from the first WAIT through the last SAMPLE
//   done      out  one-cycle completion pulse
//   truth     out  [15:0] truth[i] = f(abcd=i)
//   ones      out  [4:0]  number of ones in truth
//   match     out  truth == expected, valid from done until next start
// ---------------------------------------------------------------------------
module fto_sweep_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    output logic [3:0]  abcd,
    input  logic        f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic [4:0]  ones,
    output logic        match
);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_settle_range
            $error("fto_sweep_ctrl: SETTLE must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] idx;
    logic [3:0] cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_WAIT;
            ST_WAIT:   if (cnt == CNT_LAST) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = (idx == 4'd15) ? ST_DONE : ST_WAIT;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_WAIT, ST_SAMPLE: busy = 1'b1;
            ST_DONE:            done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: index, settle counter, abcd drive and result registers.
    // abcd is a separate register from idx so it changes only on accept,
    // on the SAMPLE->WAIT step and on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            cnt   <= '0;
            abcd  <= '0;
            truth <= '0;
            ones  <= '0;
            match <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        cnt   <= '0;
                        abcd  <= '0;
                        truth <= '0;
                        ones  <= '0;
                        match <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 4'd1;
                end
                ST_SAMPLE: begin
                    truth[idx] <= f_in;
                    ones       <= ones + {4'b0000, f_in};
                    if (idx == 4'd15) begin
                        // truth[15] is still being written this edge, so
                        // compare against the value it is about to take
                        match <= ({f_in, truth[14:0]} == expected);
                    end else begin
                        idx  <= idx + 4'd1;
                        abcd <= idx + 4'd1;
                        cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
